pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/load_use_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types and defaults for the pipeline hazard controller:
//   - state_t        : controller FSM states (RUN, MEMWAIT)
//   - WAIT_LIMIT_DEF : default data-memory wait budget before timeout
//   - CNT_W_DEF      : default performance counter width
//   - WAIT_W         : width of the memory wait counter
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  localparam int WAIT_LIMIT_DEF = 255;
  localparam int CNT_W_DEF      = 16;
  localparam int WAIT_W         = 8;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
// Combinational load-use hazard compare between the load in EX and the
// source registers of the instruction in ID.
// Ports:
//   idex_memread_i : MemRead of the instruction in EX
//   idex_rt_i      : destination (rt) of the load in EX
//   ifid_rs_i      : rs source of the instruction in ID
//   ifid_rt_i      : rt source of the instruction in ID
//   hz_o           : 1 when ID must wait one cycle for the load result
module load_use_detect (
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  output logic       hz_o
);

  // Register 0 is hard-wired to zero, so a load into it never creates a hazard.
  assign hz_o = idex_memread_i && (idex_rt_i != 5'd0) &&
                ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline hazard controller: freezes the pipe during data-memory waits,
// inserts a single bubble for load-use hazards and flushes IF/ID on taken
// branches, with a wait timeout and saturating stall/flush counters.
// Ports:
//   clk_i          : clock, rising edge
//   start_i        : asynchronous active-low reset
//   ifid_rs_i/rt_i : source registers of the instruction in ID
//   idex_memread_i : MemRead of the instruction in EX
//   idex_rt_i      : rt of the instruction in EX
//   branch_taken_i : taken branch resolved in ID
//   dmem_req_i     : MEM stage access request
//   dmem_ack_i     : data memory completion
//   pc_write_o, ifid_write_o, idex_write_o : stage load enables
//   ifid_flush_o   : clear IF/ID
//   idex_bubble_o  : zero ID/EX control fields
//   exmem_hold_o   : hold EX/MEM and MEM/WB
//   mem_timeout_o  : sticky memory wait timeout
//   stall_cnt_o    : saturating count of cycles with pc_write_o=0
//   flush_cnt_o    : saturating count of cycles with ifid_flush_o=1
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_hold_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [WAIT_W:0]   LIMIT    = (WAIT_W+1)'(WAIT_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              timeout_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  flush_cnt_reg;
  logic              hz;
  logic              mem_wait;

  load_use_detect u_load_use_detect (
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .hz_o           (hz)
  );

  // The freeze must appear in the same cycle the request misses, so the
  // stall decode is combinational from state and inputs rather than registered.
  assign mem_wait = (state_reg == MEMWAIT) || (dmem_req_i && !dmem_ack_i);

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    idex_write_o  = 1'b0;
    idex_bubble_o = 1'b0;
    ifid_flush_o  = 1'b0;
    exmem_hold_o  = 1'b0;
    if (!start_i) begin
      // everything stays disabled while held in reset
    end else if (mem_wait) begin
      exmem_hold_o = 1'b1;
    end else if (hz) begin
      // PC and IF/ID hold the dependent instruction; ID/EX loads a bubble.
      // Next cycle the load has left EX, so only one bubble is produced.
      idex_write_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else begin
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      idex_write_o = 1'b1;
      ifid_flush_o = branch_taken_i;
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      timeout_reg   <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (state_reg == RUN) begin
        if (dmem_req_i && !dmem_ack_i) begin
          state_reg    <= MEMWAIT;
          wait_cnt_reg <= '0;
        end
      end else begin
        wait_cnt_reg <= wait_cnt_reg + WAIT_ONE;
        if (dmem_ack_i) begin
          state_reg <= RUN;
        end else if (({1'b0, wait_cnt_reg} + 1'b1) >= LIMIT) begin
          // Give up on the access so the pipe cannot hang forever.
          state_reg   <= RUN;
          timeout_reg <= 1'b1;
        end
      end

      if (!pc_write_o && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      end
      if (ifid_flush_o && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
      end
    end
  end

  assign mem_timeout_o = timeout_reg;
  assign stall_cnt_o   = stall_cnt_reg;
  assign flush_cnt_o   = flush_cnt_reg;

endmodule
